// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD unit.
package gcd_pkg;

    localparam int          DEFAULT_WIDTH = 16;
    localparam logic [15:0] ITER_MAX      = 16'hFFFF;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        LATCH_A = 3'd1,
        FETCH_B = 3'd2,
        LATCH_B = 3'd3,
        CALC    = 3'd4,
        DONE    = 3'd5
    } gcd_state_e;

endpackage

// File: rtl/gcd_dp.sv
// Combinational compare/subtract step of the GCD: one rule per call, in fixed priority.
module gcd_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             done,
    output logic [WIDTH-1:0] result_next
);

    always_comb begin
        next_a      = reg_a;
        next_b      = reg_b;
        done        = 1'b0;
        result_next = reg_a;
        if (reg_a == '0) begin
            done        = 1'b1;
            result_next = reg_b;
        end else if (reg_b == '0) begin
            done        = 1'b1;
            result_next = reg_a;
        end else if (reg_a == reg_b) begin
            done        = 1'b1;
            result_next = reg_a;
        end else if (reg_a > reg_b) begin
            // Larger operand is always the minuend, so no underflow.
            next_a = reg_a - reg_b;
        end else begin
            next_b = reg_b - reg_a;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Fetches operand pairs from a registered-output FIFO and returns their GCD
// with a valid/ready result port and a saturating subtraction-step count.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [15:0]      iter_cnt,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    // Handshake: a result transfers on any rising edge where result_valid and
    // result_ready are both high; result/iter_cnt are held until then.

    gcd_state_e       state;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] result_next;
    logic             dp_done;

    gcd_dp #(.WIDTH(WIDTH)) u_dp (
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .next_a      (next_a),
        .next_b      (next_b),
        .done        (dp_done),
        .result_next (result_next)
    );

    // FIFO data is registered, so the word read in FETCH_x is captured in LATCH_x.
    assign fifo_rd   = !reset && !fifo_empty && ((state == FETCH_A) || (state == FETCH_B));
    assign busy      = !reset && (state != FETCH_A);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH_A;
            reg_a        <= '0;
            reg_b        <= '0;
            result       <= '0;
            iter_cnt     <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_A: begin
                    if (fifo_rd) state <= LATCH_A;
                end
                LATCH_A: begin
                    reg_a <= fifo_data;
                    state <= FETCH_B;
                end
                FETCH_B: begin
                    if (fifo_rd) state <= LATCH_B;
                end
                LATCH_B: begin
                    reg_b    <= fifo_data;
                    iter_cnt <= '0;
                    state    <= CALC;
                end
                CALC: begin
                    if (dp_done) begin
                        result       <= result_next;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        reg_a <= next_a;
                        reg_b <= next_b;
                        if (iter_cnt != ITER_MAX) iter_cnt <= iter_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= FETCH_A;
                    end
                end
                default: state <= FETCH_A;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboarded bench for gcd_unit: FIFO model feeds operand pairs, a monitor
// checks every accepted result against a Euclid-quotient reference.
module tb_gcd_unit;
    import gcd_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [W-1:0]  fifo_data = '0;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic [15:0]   iter_cnt;
    logic          busy;
    logic [2:0]    state_dbg;

    gcd_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_data    (fifo_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .iter_cnt     (iter_cnt),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO model (registered read data) ----------------
    logic [W-1:0] fifo_q[$];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W+15:0] exp_q[$];
    int checks  = 0;
    int fails   = 0;
    int got_cnt = 0;
    int rd_cnt  = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: test-driven

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Subtraction steps via Euclid quotients: a = q*b + r costs q subtractions,
    // or q-1 when r == 0 because the loop stops on equality.
    function automatic logic [W+15:0] ref_gcd(input int unsigned a0, input int unsigned b0);
        int unsigned a = a0;
        int unsigned b = b0;
        int unsigned t;
        int unsigned q;
        int unsigned r;
        longint unsigned steps = 0;
        logic [W-1:0] g;
        if (a == 0) g = W'(b);
        else if (b == 0) g = W'(a);
        else begin
            while (1) begin
                if (a < b) begin t = a; a = b; b = t; end
                q = a / b;
                r = a % b;
                if (r == 0) begin
                    steps += longint'(q) - 1;
                    g = W'(b);
                    break;
                end
                steps += q;
                a = r;
            end
        end
        return {g, (steps > 65535) ? 16'hFFFF : 16'(steps)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W+15:0] e;
        if (fifo_rd) begin
            rd_cnt++;
            checks++;
            if (fifo_empty) begin
                fails++;
                $display("FAIL fifo_rd_while_empty: got 1 expected 0");
            end
        end
        if (!reset && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got %0d expected none", result);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e[W+15:16]));
                check("iter_cnt", 32'(iter_cnt), 32'(e[15:0]));
            end
            got_cnt++;
        end
    end

    // ---------------- ready driver ----------------
    always @(posedge clk) begin
        #2;
        if (ready_mode == 1) result_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 0) result_ready = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        push_cnt++;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        push_word(a);
        push_word(b);
        exp_q.push_back(ref_gcd(a, b));
    endtask

    task automatic wait_results(input int target, input int budget);
        int c = 0;
        while (got_cnt < target && c < budget) begin
            step();
            c++;
        end
        check("results_by_deadline", 32'(got_cnt), 32'(target));
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!result_valid && c < budget) begin
            step();
            c++;
        end
        check("valid_by_deadline", 32'(result_valid), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int bad;
        logic [W-1:0]  held_r;
        logic [15:0]   held_i;

        // reset state
        reset = 1'b1;
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_result", 32'(result), 32'd0);
        check("post_rst_iter", 32'(iter_cnt), 32'd0);
        check("post_rst_state", 32'(state_dbg), 32'(FETCH_A));

        // 48,18: two reads, gcd 6 in 4 steps
        base = got_cnt;
        rd_cnt = 0;
        push_pair(16'd48, 16'd18);
        wait_results(base + 1, 200);
        check("rd_strobes_48_18", 32'(rd_cnt), 32'd2);

        // zero operands
        base = got_cnt;
        push_pair(16'd0, 16'd25);
        push_pair(16'd0, 16'd0);
        wait_results(base + 2, 200);

        // long run: 65535,1
        base = got_cnt;
        bad = 0;
        push_pair(16'd65535, 16'd1);
        for (int c = 0; c < 70000 && !result_valid; c++) begin
            if (state_dbg == 3'(CALC) && !busy) bad++;
            step();
        end
        check("busy_in_calc", 32'(bad), 32'd0);
        wait_results(base + 1, 100);

        // stalled result with next pair already queued
        base = got_cnt;
        ready_mode = 2;
        result_ready = 1'b0;
        push_pair(16'd12, 16'd8);
        wait_valid(200);
        push_pair(16'd30, 16'd45);
        held_r = result;
        held_i = iter_cnt;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (result !== held_r || iter_cnt !== held_i || fifo_rd || !result_valid) bad++;
        end
        check("stall_hold", 32'(bad), 32'd0);
        check("stall_result", 32'(held_r), 32'd4);
        result_ready = 1'b1;
        step();
        check("fetch_after_handshake", 32'(fifo_rd), 32'd1);
        check("valid_drop_after_handshake", 32'(result_valid), 32'd0);
        ready_mode = 0;
        wait_results(base + 2, 400);

        // only operand A available: stall in FETCH_B
        base = got_cnt;
        bad = 0;
        push_word(16'd35);
        step(4);
        for (int c = 0; c < 20; c++) begin
            if (fifo_rd || state_dbg != 3'(FETCH_B)) bad++;
            step();
        end
        check("fetch_b_stall", 32'(bad), 32'd0);
        push_word(16'd21);
        exp_q.push_back(ref_gcd(35, 21));
        wait_results(base + 1, 200);

        // reset during CALC discards the pair
        base = got_cnt;
        push_word(16'd1000);
        push_word(16'd3);
        for (int c = 0; c < 50 && state_dbg != 3'(CALC); c++) step();
        step(5);
        check("in_calc_before_reset", 32'(state_dbg), 32'(CALC));
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        step();
        reset = 1'b0;
        check("after_rst_valid", 32'(result_valid), 32'd0);
        check("after_rst_busy", 32'(busy), 32'd0);
        check("after_rst_iter", 32'(iter_cnt), 32'd0);
        push_pair(16'd9, 16'd6);
        wait_results(base + 1, 200);

        // randomized pairs with random backpressure
        base = got_cnt;
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            push_pair(W'($urandom_range(0, 400)), W'($urandom_range(0, 400)));
        end
        wait_results(base + 20, 25000);
        ready_mode = 0;

        step(5);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
